pol2rec: RTL and testbench
==========================

Name: pol2rec

Overview:
- Converts polar coordinates to rectangular: (mod 16Q16, angle in degrees 8Q24) to (x, y 16Q16).
- Uses iterative CORDIC in rotation mode, one micro-rotation per enabled clock.
- Inverse companion of the vectoring-mode rec2pol converter in the same datapath; shares the same number formats, so rec2pol output can feed pol2rec directly.
- Adds a start/busy/done handshake and pre-rotation for angles beyond ±90°.

Parameters:
- NITER, 24, number of CORDIC micro-rotations (legal range 16..30).
- KINV, 32'h4DBA76D4, CORDIC gain compensation 1/K = 0.6072529350 in 1Q31.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- enable  in  1  clock enable; when low, all state including the FSM holds.
- start  in  1  request conversion; sampled only in IDLE with enable=1.
- mod  in  32  signed modulus, 16Q16; must be ≥ 0.
- angle  in  32  signed angle in degrees, 8Q24; full range [-128°, +128°).
- x  out  32  signed X result, 16Q16, registered.
- y  out  32  signed Y result, 16Q16, registered.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when x/y update.

Behaviour:
- Reset (reset=0, async): FSM to IDLE; x=0, y=0, busy=0, done=0; internal xr, yr, zr and the iteration counter cleared.
- Reset mid-operation aborts the conversion with no done pulse.
- FSM states are IDLE, LOAD, ITER, DONE. Transitions occur only on clock edges with enable=1.
- IDLE:
  - start=1: latch mod and angle, set busy=1, go to LOAD.
  - start while not IDLE is ignored, with no queueing.
- LOAD (1 cycle):
  - Gain compensation: ms = (mod × KINV) >>> 31, with a 64-bit signed product truncated toward -inf.
  - Pre-rotation, with xr, yr as 34-bit signed and zr as 32-bit:
    - angle > +90° (0x5A000000): xr=0, yr=+ms, zr=angle−90°.
    - angle < −90°: xr=0, yr=−ms, zr=angle+90°.
    - otherwise: xr=ms, yr=0, zr=angle.
  - Clear counter i=0, go to ITER.
- ITER (NITER cycles, i = 0..NITER−1):
  - zr ≥ 0 (zr[31]=0): xr ← xr − (yr>>>i); yr ← yr + (xr>>>i); zr ← zr − ATAN[i].
  - zr < 0: xr ← xr + (yr>>>i); yr ← yr − (xr>>>i); zr ← zr + ATAN[i].
  - All updates use old register values (simultaneous).
  - ATAN[i] = atan(2^-i) in degrees, 8Q24, from the shared ATAN_ROM table.
  - When i = NITER−1, go to DONE.
- DONE (1 cycle):
  - x and y load xr and yr saturated to 32 bits: above 0x7FFFFFFF clamps to 0x7FFFFFFF; below 0x80000000 clamps to 0x80000000.
  - done=1 for this cycle, busy=0.
  - Return to IDLE.
- Latency: the edge accepting start is cycle 0; done is high after edge NITER+2 (26 cycles at the default).
- x and y hold their values until the next DONE.
- A new start is accepted in the IDLE cycle immediately after DONE (back-to-back throughput NITER+3 cycles).
- enable=0 in any state freezes the FSM, counter, xr/yr/zr, x/y and busy.
  - done is held at 0 while stalled; an in-progress DONE asserts when enable returns.
- Boundaries:
  - angle exactly ±90°: no pre-rotation.
  - mod=0: result 0,0.
  - Negative mod: result is the point reflected through the origin; no error flag.
- Accuracy: |error| ≤ 8 LSB per component for mod ≤ 16.0 at NITER=24.

Test Plan:
- reset low mid-ITER (after 10 cycles), then release, then start mod=1.0 angle=0 -> no done during the aborted run; outputs 0 after reset; second run gives x≈0x00010000, y≈0x00000000 (±8 LSB), done 26 cycles after start.
- mod=0x00010000, angle=0x5A000000 (90°) -> x≈0, y≈0x00010000 ±8 LSB.
- mod=0x00020000 (2.0), angle=0x2D000000 (45°) -> x≈y≈0x00016A0A ±8 LSB.
- mod=0x00010000, angle=0x88000000 (−120°) -> pre-rotation path; x≈0xFFFF8000, y≈0xFFFF224C ±8 LSB.
- Toggle enable low for 5 cycles during ITER and pulse start while busy -> done delayed by exactly 5 cycles, result unchanged; the extra start is ignored with no second done.
- mod=0x7FFFFFFF, angle=0 -> x saturates/holds ≤0x7FFFFFFF with no sign wrap; y≈0.

Source files
------------

// File: rtl/pol2rec.sv
// Purpose : polar (mod 16Q16, angle deg 8Q24) to rectangular (x, y 16Q16) via iterative CORDIC rotation.
// Latency : start accepted on edge 0, done pulses after edge NITER+2; back-to-back every NITER+3 cycles.
// Backpressure: none; start is ignored while busy, enable=0 freezes all state and holds done low.
//
// Ports:
//   clock, reset (async, active low), enable (clock enable)
//   start         - request; sampled only in IDLE with enable=1
//   mod, angle    - signed 16Q16 modulus, signed 8Q24 angle in degrees
//   x, y          - signed 16Q16 results, saturated, held until the next conversion
//   busy, done    - busy from the cycle after accept until done; done is a one-cycle pulse
module pol2rec #(
    parameter int          NITER = 24,
    parameter logic [31:0] KINV  = 32'h4DBA76D4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic signed [31:0] mod,
    input  logic signed [31:0] angle,
    output logic signed [31:0] x,
    output logic signed [31:0] y,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

    localparam logic signed [31:0] DEG90  = 32'sh5A000000;
    localparam logic signed [31:0] NDEG90 = -32'sh5A000000;
    localparam logic [4:0]         LAST   = 5'(NITER - 1);

    state_t             state, state_nx;
    logic [4:0]         cnt;
    logic signed [31:0] mod_q, angle_q;
    logic signed [33:0] xr, yr;
    logic signed [31:0] zr;

    logic signed [63:0] prod;
    logic signed [33:0] ms;
    logic signed [33:0] xs, ys;
    logic signed [31:0] at;

    // atan(2^-i) in degrees, 8Q24
    function automatic logic signed [31:0] atan_rom(input logic [4:0] i);
        case (i)
            5'd0:  atan_rom = 32'sd754974720;
            5'd1:  atan_rom = 32'sd445687602;
            5'd2:  atan_rom = 32'sd235489088;
            5'd3:  atan_rom = 32'sd119537938;
            5'd4:  atan_rom = 32'sd60000934;
            5'd5:  atan_rom = 32'sd30029717;
            5'd6:  atan_rom = 32'sd15018523;
            5'd7:  atan_rom = 32'sd7509720;
            5'd8:  atan_rom = 32'sd3754917;
            5'd9:  atan_rom = 32'sd1877466;
            5'd10: atan_rom = 32'sd938734;
            5'd11: atan_rom = 32'sd469367;
            5'd12: atan_rom = 32'sd234684;
            5'd13: atan_rom = 32'sd117342;
            5'd14: atan_rom = 32'sd58671;
            5'd15: atan_rom = 32'sd29335;
            5'd16: atan_rom = 32'sd14668;
            5'd17: atan_rom = 32'sd7334;
            5'd18: atan_rom = 32'sd3667;
            5'd19: atan_rom = 32'sd1833;
            5'd20: atan_rom = 32'sd917;
            5'd21: atan_rom = 32'sd458;
            5'd22: atan_rom = 32'sd229;
            5'd23: atan_rom = 32'sd115;
            5'd24: atan_rom = 32'sd57;
            5'd25: atan_rom = 32'sd29;
            5'd26: atan_rom = 32'sd14;
            5'd27: atan_rom = 32'sd7;
            5'd28: atan_rom = 32'sd4;
            5'd29: atan_rom = 32'sd2;
            default: atan_rom = 32'sd0;
        endcase
    endfunction

    // Clamp the 34-bit working value into the 32-bit output range
    function automatic logic signed [31:0] sat34(input logic signed [33:0] v);
        if (v[33:31] == 3'b000 || v[33:31] == 3'b111)
            sat34 = v[31:0];
        else if (v[33])
            sat34 = 32'sh80000000;
        else
            sat34 = 32'sh7FFFFFFF;
    endfunction

    // Gain pre-compensation: floor((mod * 1/K) / 2^31)
    assign prod = 64'(mod_q) * 64'(signed'(KINV));
    assign ms   = 34'(prod >>> 31);

    assign xs = xr >>> cnt;
    assign ys = yr >>> cnt;
    assign at = atan_rom(cnt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else if (enable)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = ITER;
            ITER:    if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mod_q   <= '0;
            angle_q <= '0;
            xr      <= '0;
            yr      <= '0;
            zr      <= '0;
            cnt     <= '0;
            x       <= '0;
            y       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // done is a pulse and also stays low through any stall
            done <= 1'b0;
            if (enable) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mod_q   <= mod;
                            angle_q <= angle;
                            busy    <= 1'b1;
                        end
                    end
                    LOAD: begin
                        // Fold angles beyond +-90 deg onto the y axis so the
                        // residual stays inside the CORDIC convergence range.
                        if (angle_q > DEG90) begin
                            xr <= '0;
                            yr <= ms;
                            zr <= angle_q - DEG90;
                        end else if (angle_q < NDEG90) begin
                            xr <= '0;
                            yr <= -ms;
                            zr <= angle_q + DEG90;
                        end else begin
                            xr <= ms;
                            yr <= '0;
                            zr <= angle_q;
                        end
                        cnt <= '0;
                    end
                    ITER: begin
                        if (!zr[31]) begin
                            xr <= xr - ys;
                            yr <= yr + xs;
                            zr <= zr - at;
                        end else begin
                            xr <= xr + ys;
                            yr <= yr - xs;
                            zr <= zr + at;
                        end
                        cnt <= cnt + 5'd1;
                    end
                    DONE: begin
                        x    <= sat34(xr);
                        y    <= sat34(yr);
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pol2rec.sv
// Purpose : randomized and directed stimulus for pol2rec, scoreboard-checked against a trig model.
// Latency : expected done cycle is tracked per transaction, including injected stalls.
// Backpressure: enable stalls and ignored starts while busy are exercised.
module tb_pol2rec;

    localparam int NITER = 24;

    logic               clock  = 1'b0;
    logic               rst_n  = 1'b0;
    logic               enable = 1'b0;
    logic               start  = 1'b0;
    logic signed [31:0] mod    = '0;
    logic signed [31:0] angle  = '0;
    logic signed [31:0] x, y;
    logic               busy, done;

    int     checks = 0;
    int     errors = 0;
    int     nid    = 0;
    longint cyc    = 0;

    typedef struct {
        logic signed [31:0] ex;
        logic signed [31:0] ey;
        longint             tol_x;
        longint             tol_y;
        longint             ecyc;
        int                 id;
    } exp_t;

    exp_t sb[$];

    pol2rec #(.NITER(NITER), .KINV(32'h4DBA76D4)) dut (
        .clock  (clock),
        .reset  (rst_n),
        .enable (enable),
        .start  (start),
        .mod    (mod),
        .angle  (angle),
        .x      (x),
        .y      (y),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Ideal rectangular component in 16Q16, rounded and clamped to 32 bits
    function automatic logic signed [31:0] ref_comp(input logic signed [31:0] m,
                                                    input logic signed [31:0] a,
                                                    input bit sine);
        real    rad, v;
        longint li;
        rad = ($itor(a) / 16777216.0) * 3.14159265358979 / 180.0;
        v   = $itor(m) * (sine ? $sin(rad) : $cos(rad));
        if (v > 2147483647.0)  v = 2147483647.0;
        if (v < -2147483648.0) v = -2147483648.0;
        li = longint'(v);
        return 32'(li);
    endfunction

    task automatic chk(input string nm, input longint act, input longint req, input longint tol);
        longint d;
        checks++;
        d = act - req;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d tol=%0d cyc=%0d", nm, act, req, tol, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("x[%0d]", e.id), longint'(x), longint'(e.ex), e.tol_x);
                chk($sformatf("y[%0d]", e.id), longint'(y), longint'(e.ey), e.tol_y);
                chk($sformatf("done_cycle[%0d]", e.id), cyc, e.ecyc, 0);
                chk($sformatf("busy_at_done[%0d]", e.id), longint'(busy), 0, 0);
            end
        end
    end

    // Called at a negedge; start is sampled on the following posedge
    task automatic issue(input logic signed [31:0] m, input logic signed [31:0] a,
                         input longint tx, input longint ty, input int stall);
        exp_t e;
        mod   = m;
        angle = a;
        start = 1'b1;
        e.ex    = ref_comp(m, a, 1'b0);
        e.ey    = ref_comp(m, a, 1'b1);
        e.tol_x = tx;
        e.tol_y = ty;
        e.ecyc  = cyc + 1 + NITER + 2 + stall;
        e.id    = nid;
        nid++;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (sb.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run1(input logic signed [31:0] m, input logic signed [31:0] a);
        issue(m, a, 8, 8, 0);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] rm, ra;

        // Reset state
        enable = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_x", longint'(x), 0, 0);
        chk("rst_y", longint'(y), 0, 0);
        chk("rst_busy", longint'(busy), 0, 0);
        chk("rst_done", longint'(done), 0, 0);
        rst_n = 1'b1;
        @(negedge clock);

        // 90 deg, no pre-rotation; also leaves nonzero outputs for the abort test
        run1(32'sh00010000, 32'sh5A000000);

        // Abort mid-ITER: no expectation queued, so any done is flagged
        mod   = 32'sh00010000;
        angle = 32'sh1E000000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        chk("busy_mid_run", longint'(busy), 1, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_x", longint'(x), 0, 0);
        chk("abort_y", longint'(y), 0, 0);
        chk("abort_busy", longint'(busy), 0, 0);
        chk("abort_done", longint'(done), 0, 0);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // Directed cases
        run1(32'sh00010000, 32'sh00000000);   // 1.0 at 0 deg
        run1(32'sh00020000, 32'sh2D000000);   // 2.0 at 45 deg
        run1(32'sh00010000, 32'sh88000000);   // -120 deg, pre-rotated
        run1(32'sh00010000, 32'sh78000000);   // +120 deg, pre-rotated
        run1(32'sh00030000, 32'shA6000000);   // exactly -90 deg
        run1(32'sh00000000, 32'sh3C000000);   // mod 0
        run1(32'shFFFF0000, 32'sh1E000000);   // negative mod reflects
        run1(32'sh00100000, 32'sh80000000);   // 16.0 at -128 deg

        // Stall of 5 cycles during ITER plus a start pulse while busy
        issue(32'sh00018000, 32'sh14000000, 8, 8, 5);
        repeat (6) @(negedge clock);
        enable = 1'b0;
        repeat (5) @(negedge clock);
        chk("busy_in_stall", longint'(busy), 1, 0);
        enable = 1'b1;
        repeat (2) @(negedge clock);
        mod   = 32'sh00050000;
        angle = 32'shC0000000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clock);

        // Back-to-back: start held high is taken again in the IDLE cycle after DONE
        begin
            exp_t e;
            mod   = 32'sh00008000;
            angle = 32'shE2000000;
            start = 1'b1;
            for (int k = 0; k < 2; k++) begin
                e.ex    = ref_comp(mod, angle, 1'b0);
                e.ey    = ref_comp(mod, angle, 1'b1);
                e.tol_x = 8;
                e.tol_y = 8;
                e.ecyc  = cyc + 1 + NITER + 2 + k * (NITER + 3);
                e.id    = nid;
                nid++;
                sb.push_back(e);
            end
            repeat (NITER + 4) @(negedge clock);
            start = 1'b0;
            wait_idle();
            repeat (40) @(negedge clock);
        end

        // Saturation: largest modulus must clamp, never wrap negative
        issue(32'sh7FFFFFFF, 32'sh00000000, 64, 1024, 0);
        wait_idle();

        // Randomized modulus in [-16, +16] and full angle range
        for (int t = 0; t < 20; t++) begin
            rm = $signed(32'($urandom_range(0, 32'h00200000))) - 32'sh00100000;
            ra = $signed($urandom);
            run1(rm, ra);
        end

        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
